// File: rtl/reply_packer.sv
// reply_packer: buffers one reply packet from the register manager, then streams it to the FX2 IN endpoint.
// A zero-byte packet becomes a zero-length-packet request.
module reply_packer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  reply_in,
  input  logic        reply_rdy,
  output logic        reply_ack,
  input  logic        reply_end,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        out_zlp,
  input  logic        out_ready,
  output logic [15:0] pkt_count,
  output logic        overflow,
  output logic        proto_err
);
  typedef enum logic {COLLECT, FLUSH} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);
  state_t state_q, state_d;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_zlp_q, out_zlp_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic overflow_q, overflow_d, proto_err_q, proto_err_d;
  logic wr_en;
  always_comb begin
    reply_ack   = reply_rdy && state_q == COLLECT;
    wr_en       = reply_ack && count_q != FULL;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_zlp_d   = out_zlp_q;
    pkt_count_d = pkt_count_q;
    overflow_d  = overflow_q || (reply_ack && count_q == FULL);
    proto_err_d = proto_err_q || (reply_end && state_q == FLUSH);
    if (state_q == COLLECT) begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      if (reply_end) begin
        state_d     = FLUSH;
        out_valid_d = count_d != '0;
        out_zlp_d   = count_d == '0;
        out_last_d  = count_d == ONE;
        // An empty buffer means the byte being written this cycle is the head.
        out_data_d  = count_q == '0 ? reply_in : mem[rd_ptr_q];
      end
    end else begin
      if (out_valid_q && out_ready) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        count_d     = count_q - 1'b1;
        out_valid_d = count_q != ONE;
        out_last_d  = count_q == TWO;
        out_data_d  = mem[rd_ptr_d];
        state_d     = count_q == ONE ? COLLECT : FLUSH;
        pkt_count_d = count_q == ONE ? pkt_count_q + 16'd1 : pkt_count_q;
      end
      if (out_zlp_q && out_ready) begin
        out_zlp_d   = 1'b0;
        state_d     = COLLECT;
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_zlp_q   <= 1'b0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_zlp_q   <= out_zlp_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= reply_in;
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_zlp   = out_zlp_q;
  assign pkt_count = pkt_count_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_reply_packer.sv
// tb_reply_packer: randomized scoreboard bench; a packet-level model predicts beats, a monitor pops and compares.
module tb_reply_packer;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] reply_in = '0;
  logic reply_rdy = 1'b0, reply_end = 1'b0, out_ready = 1'b0;
  logic reply_ack, out_valid, out_last, out_zlp, overflow, proto_err;
  logic [7:0] out_data;
  logic [15:0] pkt_count;
  typedef struct {bit zlp; logic [7:0] d; bit last;} item_t;
  item_t expq[$];
  logic [7:0] pend[$];
  int exp_pkts = 0, mode = 0, beat_cnt = 0;
  bit exp_ovf = 0, exp_perr = 0;
  int s_checks = 0, s_errs = 0, m_checks = 0, m_errs = 0;
  reply_packer #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .reply_in(reply_in), .reply_rdy(reply_rdy), .reply_ack(reply_ack),
    .reply_end(reply_end), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_zlp(out_zlp), .out_ready(out_ready), .pkt_count(pkt_count), .overflow(overflow),
    .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  // out_ready pattern: 0 always high, 1 toggling, 2 random, 3 held low
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge clk) begin
    item_t it;
    if (reset_n) begin
      m_checks++;
      if (out_valid && out_zlp) begin
        m_errs++;
        $display("FAIL exclusive: out_valid and out_zlp both high");
      end
      m_checks++;
      if (reply_ack !== (reply_rdy && !out_valid && !out_zlp)) begin
        m_errs++;
        $display("FAIL ack: got %b expected %b", reply_ack, reply_rdy && !out_valid && !out_zlp);
      end
      if ((out_valid || out_zlp) && out_ready) begin
        m_checks++;
        if (expq.size() == 0) begin
          m_errs++;
          $display("FAIL unexpected_output: zlp=%b data=%h with nothing expected", out_zlp, out_data);
        end else begin
          it = expq.pop_front();
          if (it.zlp !== out_zlp || (out_valid && (out_data !== it.d || out_last !== it.last))) begin
            m_errs++;
            $display("FAIL beat: got zlp=%b data=%h last=%b expected zlp=%b data=%h last=%b",
                     out_zlp, out_data, out_last, it.zlp, it.d, it.last);
          end
        end
        if (out_valid) beat_cnt++;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    s_checks++;
    if (act !== exp) begin
      s_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic take(input logic [7:0] b);
    if (pend.size() < DEPTH) pend.push_back(b);
    else exp_ovf = 1;
  endtask
  task automatic finish_pkt();
    item_t it;
    if (pend.size() == 0) begin
      it.zlp = 1; it.d = '0; it.last = 0;
      expq.push_back(it);
    end else for (int i = 0; i < pend.size(); i++) begin
      it.zlp = 0; it.d = pend[i]; it.last = (i == pend.size() - 1);
      expq.push_back(it);
    end
    pend.delete();
    exp_pkts++;
  endtask
  task automatic offer(input logic [7:0] b, input bit with_end);
    bit got = 0;
    reply_in = b;
    reply_rdy = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = reply_ack;
    end
    if (!got) chk("ack_timeout", 0, 1);
    reply_end = with_end;
    @(posedge clk);
    #1;
    reply_rdy = 1'b0;
    reply_end = 1'b0;
    if (got) begin
      take(b);
      if (with_end) finish_pkt();
    end
  endtask
  task automatic end_pkt();
    reply_end = 1'b1;
    @(posedge clk);
    #1;
    reply_end = 1'b0;
    finish_pkt();
  endtask
  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = expq.size() == 0 && !out_valid && !out_zlp;
    end
    chk({name, "_drain_timeout"}, 32'(done), 1);
    chk({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts[15:0]));
    chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({name, "_proto_err"}, 32'(proto_err), 32'(exp_perr));
  endtask
  task automatic do_reset();
    reply_rdy = 1'b0;
    reply_end = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_zlp", 32'(out_zlp), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    chk("rst_flags", {30'd0, overflow, proto_err}, 0);
    expq.delete();
    pend.delete();
    exp_pkts = 0;
    exp_ovf = 0;
    exp_perr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    int base;
    bit we;
    do_reset();
    // 1: three bytes, first beat one cycle after reply_end
    offer(8'h01, 0); offer(8'hA5, 0); offer(8'h3C, 0);
    end_pkt();
    @(negedge clk);
    chk("t1_latency_valid", 32'(out_valid), 1);
    chk("t1_first_data", 32'(out_data), 32'h01);
    drain("t1");
    // 2: zero-length packet held while out_ready is low
    mode = 3;
    repeat (2) @(posedge clk);
    #1;
    end_pkt();
    repeat (4) begin
      @(negedge clk);
      chk("t2_zlp_hold", 32'(out_zlp), 1);
      chk("t2_no_valid", 32'(out_valid), 0);
    end
    mode = 0;
    drain("t2");
    // 3: overflow, only the first DEPTH bytes are sent
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH + 2; i++) offer(8'(i), 0);
    end_pkt();
    drain("t3");
    // 4: toggling ready, second packet offered during flush
    mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) offer(8'($urandom), 0);
    end_pkt();
    for (int i = 0; i < 4; i++) offer(8'($urandom), 0);
    end_pkt();
    drain("t4");
    mode = 0;
    // 5: asynchronous reset after two of five beats
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) offer(8'($urandom), 0);
    base = beat_cnt;
    end_pkt();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_beats_before_reset", 32'(beat_cnt - base), 2);
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) offer(8'($urandom), i == 4);
    drain("t5");
    // 6: 20 back-to-back packets across pointer wrap, stray reply_end in flush
    do_reset();
    mode = 2;
    for (int p = 0; p < 20; p++) begin
      we = 1'($urandom_range(0, 1));
      for (int i = 0; i < 12; i++) offer(8'($urandom), we && i == 11);
      if (!we) end_pkt();
      if (p == 7) begin
        reply_end = 1'b1;
        @(posedge clk);
        #1;
        reply_end = 1'b0;
        exp_perr = 1;
      end
    end
    drain("t6");
    chk("t6_pkt_count", 32'(pkt_count), 20);
    chk("t6_proto_err", 32'(proto_err), 1);
    $display("Simulation finished: %0d checks, %0d errors", s_checks + m_checks, s_errs + m_errs);
    $finish;
  end
endmodule
